// File: rtl/snn_pkg.sv
// Shared types and constants for the spike emitter and its AER transmitter.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIRE,
        EMIT
    } emit_state_t;

    // Field widths cover the largest supported core; users slice to their own widths.
    localparam int AER_ADDR_MAX_W = 16;
    localparam int AER_TS_MAX_W   = 32;

    typedef struct packed {
        logic [AER_ADDR_MAX_W-1:0] addr;
        logic [AER_TS_MAX_W-1:0]   ts;
    } aer_event_t;

    localparam int RESET_ZERO = 0;
    localparam int RESET_SUB  = 1;

endpackage

// File: rtl/aer_tx.sv
// Scans a fired-neuron vector in ascending order and emits one AER event per
// set bit over a valid/ready handshake; skipped neurons cost one cycle each.
module aer_tx
    import snn_pkg::*;
#(
    parameter int N    = 8,
    parameter int TS_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N-1:0]         start_vec,
    input  logic [N-1:0]         spk_vec,
    input  logic [TS_W-1:0]      ts,
    output logic                 finish,
    output logic                 aer_valid,
    input  logic                 aer_ready,
    output logic [$clog2(N)-1:0] aer_addr,
    output logic [TS_W-1:0]      aer_ts
);

    localparam int AW = $clog2(N);

    logic          active;
    logic [AW-1:0] idx;
    logic [AW-1:0] nxt;
    logic          advance;
    logic          last;

    assign nxt      = idx + AW'(1);
    assign last     = (idx == AW'(N - 1));
    assign advance  = active && (!aer_valid || aer_ready);
    assign finish   = advance && last;
    assign aer_addr = idx;

    // start_vec is the fire vector being registered into spk_vec on this same
    // edge, so the first slot's valid is taken from it rather than from spk_vec.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active    <= 1'b0;
            idx       <= '0;
            aer_valid <= 1'b0;
            aer_ts    <= '0;
        end else if (start) begin
            active    <= 1'b1;
            idx       <= '0;
            aer_valid <= start_vec[0];
            aer_ts    <= ts;
        end else if (advance) begin
            if (last) begin
                active    <= 1'b0;
                idx       <= '0;
                aer_valid <= 1'b0;
            end else begin
                idx       <= nxt;
                aer_valid <= spk_vec[nxt];
            end
        end
    end

endmodule

// File: rtl/spike_emitter.sv
// Timestep driver: runs the crossbar core, thresholds and resets membranes,
// feeds spikes/membranes back, and hands fired neurons to the AER transmitter.
module spike_emitter
    import snn_pkg::*;
#(
    parameter int MAX_NEURONS = 8,
    parameter int WIDTH       = 32,
    parameter int THRESH      = 32,
    parameter int RESET_MODE  = RESET_ZERO,
    parameter int TS_W        = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           step_start,
    output logic                           core_enable,
    input  logic                           core_done,
    input  logic [WIDTH*MAX_NEURONS-1:0]   mem_acc,
    output logic [WIDTH*MAX_NEURONS-1:0]   mem_next,
    output logic [MAX_NEURONS-1:0]         spk_vec,
    output logic                           aer_valid,
    input  logic                           aer_ready,
    output logic [$clog2(MAX_NEURONS)-1:0] aer_addr,
    output logic [TS_W-1:0]                aer_ts,
    output logic                           busy,
    output logic                           step_done,
    output logic [TS_W-1:0]                step_count
);

    localparam logic signed [WIDTH-1:0] TH = WIDTH'(THRESH);

    emit_state_t                  state;
    logic [MAX_NEURONS-1:0]       fire_vec;
    logic [WIDTH*MAX_NEURONS-1:0] mem_upd;
    logic                         tx_finish;

    always_comb begin
        fire_vec = '0;
        mem_upd  = '0;
        for (int unsigned i = 0; i < MAX_NEURONS; i++) begin
            fire_vec[i] = ($signed(mem_acc[i*WIDTH +: WIDTH]) >= TH);
            if (!fire_vec[i]) begin
                mem_upd[i*WIDTH +: WIDTH] = mem_acc[i*WIDTH +: WIDTH];
            end else if (RESET_MODE == RESET_SUB) begin
                mem_upd[i*WIDTH +: WIDTH] = mem_acc[i*WIDTH +: WIDTH] - TH;
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            core_enable <= 1'b0;
            spk_vec     <= '0;
            mem_next    <= '0;
            step_done   <= 1'b0;
            step_count  <= '0;
        end else begin
            step_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (step_start) begin
                        state       <= RUN;
                        core_enable <= 1'b1;
                    end
                end
                RUN: begin
                    if (core_done) state <= FIRE;
                end
                FIRE: begin
                    spk_vec     <= fire_vec;
                    mem_next    <= mem_upd;
                    core_enable <= 1'b0;
                    state       <= EMIT;
                end
                EMIT: begin
                    if (tx_finish) begin
                        state      <= IDLE;
                        step_done  <= 1'b1;
                        step_count <= step_count + TS_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    aer_tx #(
        .N    (MAX_NEURONS),
        .TS_W (TS_W)
    ) u_aer_tx (
        .clk       (clk),
        .rst       (rst),
        .start     (state == FIRE),
        .start_vec (fire_vec),
        .spk_vec   (spk_vec),
        .ts        (step_count),
        .finish    (tx_finish),
        .aer_valid (aer_valid),
        .aer_ready (aer_ready),
        .aer_addr  (aer_addr),
        .aer_ts    (aer_ts)
    );

endmodule

// File: tb/tb_spike_emitter.sv
// Directed bench: two emitters (reset-to-zero / 16-bit count, subtract / 3-bit count)
// share stimulus; per-step vectors plus hand sequences for stall, guard, wrap and reset.
module tb_spike_emitter;
    import snn_pkg::*;

    typedef logic [3:0][31:0] quad_t;

    typedef struct packed {
        quad_t      mem;
        logic [3:0] spk;
        quad_t      m0;
        quad_t      m1;
        int         n_ev;
        quad_t      ev;
        int         stall_addr;
        int         stall_cyc;
        int         lat;
        bit         guard;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         step_start;
    logic         core_done;
    logic [127:0] mem_acc;
    logic         aer_ready;

    logic         ce0, v0, busy0, sd0;
    logic [127:0] mem0;
    logic [3:0]   spk0;
    logic [1:0]   a0;
    logic [15:0]  ts0, sc0;

    logic         ce1, v1, busy1, sd1;
    logic [127:0] mem1;
    logic [3:0]   spk1;
    logic [1:0]   a1;
    logic [2:0]   ts1, sc1;

    int checks   = 0;
    int failures = 0;
    int exp_steps = 0;

    always #5 clk = ~clk;

    spike_emitter #(
        .MAX_NEURONS (4), .WIDTH (32), .THRESH (32), .RESET_MODE (0), .TS_W (16)
    ) dut0 (
        .clk (clk), .rst (rst), .step_start (step_start),
        .core_enable (ce0), .core_done (core_done),
        .mem_acc (mem_acc), .mem_next (mem0), .spk_vec (spk0),
        .aer_valid (v0), .aer_ready (aer_ready), .aer_addr (a0), .aer_ts (ts0),
        .busy (busy0), .step_done (sd0), .step_count (sc0)
    );

    spike_emitter #(
        .MAX_NEURONS (4), .WIDTH (32), .THRESH (32), .RESET_MODE (1), .TS_W (3)
    ) dut1 (
        .clk (clk), .rst (rst), .step_start (step_start),
        .core_enable (ce1), .core_done (core_done),
        .mem_acc (mem_acc), .mem_next (mem1), .spk_vec (spk1),
        .aer_valid (v1), .aer_ready (aer_ready), .aer_addr (a1), .aer_ts (ts1),
        .busy (busy1), .step_done (sd1), .step_count (sc1)
    );

    function automatic quad_t quad(input int e0, input int e1, input int e2, input int e3);
        quad_t q;
        q[0] = e0; q[1] = e1; q[2] = e2; q[3] = e3;
        return q;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic run_step(input vec_t v);
        aer_event_t q[$];
        int   iter;
        int   stall_n;
        bit   done;
        bit   held;
        logic [1:0]  pa;
        logic [15:0] pts;
        q.delete();
        stall_n = 0;
        held    = 1'b0;
        pa      = '0;
        pts     = '0;
        mem_acc    = v.mem;
        aer_ready  = 1'b1;
        core_done  = 1'b0;
        step_start = 1'b1;
        @(negedge clk);
        step_start = 1'b0;
        chk("run_enable_busy", {ce0, busy0}, 2'b11);
        @(negedge clk);
        core_done = 1'b1;
        iter = 0;
        done = 1'b0;
        while (!done && iter < 200) begin
            @(negedge clk);
            iter++;
            if (!ce0) core_done = 1'b0;
            if (sd0) begin
                done       = 1'b1;
                step_start = 1'b0;
            end else begin
                step_start = v.guard;
                if (held) chk("hold_stable", {v0, a0, ts0}, {1'b1, pa, pts});
                if (v0) begin
                    if (int'(a0) == v.stall_addr && stall_n < v.stall_cyc) begin
                        aer_ready = 1'b0;
                        stall_n++;
                    end else begin
                        aer_ready = 1'b1;
                        q.push_back('{addr: 16'(a0), ts: 32'(ts0)});
                    end
                end else begin
                    aer_ready = 1'b1;
                end
                held = v0 && !aer_ready;
                pa   = a0;
                pts  = ts0;
            end
        end
        if (!done) chk("step_timeout", 0, 1);
        chk("latency", iter, v.lat);
        chk("ev_count", q.size(), v.n_ev);
        for (int i = 0; i < q.size() && i < v.n_ev; i++) begin
            chk("ev_addr", q[i].addr, v.ev[i]);
            chk("ev_ts", q[i].ts, 32'(exp_steps % 65536));
        end
        exp_steps++;
        chk("spk_mode0", spk0, v.spk);
        chk("spk_mode1", spk1, v.spk);
        chk("mem_mode0", mem0, v.m0);
        chk("mem_mode1", mem1, v.m1);
        chk("count16", sc0, exp_steps % 65536);
        chk("count3", sc1, exp_steps % 8);
        aer_ready = 1'b1;
        @(negedge clk);
        chk("done_pulse_end", {sd0, busy0, v0}, 3'b000);
        if (v.guard) begin
            repeat (2) @(negedge clk);
            chk("guard_no_step", {busy0, sc0}, {1'b0, 16'(exp_steps)});
        end
    endtask

    vec_t vt[5];

    initial begin
        vt[0] = '{mem: quad(40, 31, 32, -5), spk: 4'b0101,
                  m0: quad(0, 31, 0, -5), m1: quad(8, 31, 0, -5),
                  n_ev: 2, ev: quad(0, 2, 0, 0), stall_addr: -1, stall_cyc: 0,
                  lat: 6, guard: 1'b0};
        vt[1] = '{mem: quad(100, 32, 0, -40), spk: 4'b0011,
                  m0: quad(0, 0, 0, -40), m1: quad(68, 0, 0, -40),
                  n_ev: 2, ev: quad(0, 1, 0, 0), stall_addr: -1, stall_cyc: 0,
                  lat: 6, guard: 1'b0};
        vt[2] = '{mem: quad(0, -1, 31, -100), spk: 4'b0000,
                  m0: quad(0, -1, 31, -100), m1: quad(0, -1, 31, -100),
                  n_ev: 0, ev: quad(0, 0, 0, 0), stall_addr: -1, stall_cyc: 0,
                  lat: 6, guard: 1'b1};
        vt[3] = '{mem: quad(32, 33, 64, 2147483647), spk: 4'b1111,
                  m0: quad(0, 0, 0, 0), m1: quad(0, 1, 32, 2147483615),
                  n_ev: 4, ev: quad(0, 1, 2, 3), stall_addr: 1, stall_cyc: 5,
                  lat: 11, guard: 1'b0};
        vt[4] = '{mem: quad(int'(32'h8000_0000), 31, 1000, 32), spk: 4'b1100,
                  m0: quad(int'(32'h8000_0000), 31, 0, 0),
                  m1: quad(int'(32'h8000_0000), 31, 968, 0),
                  n_ev: 2, ev: quad(2, 3, 0, 0), stall_addr: -1, stall_cyc: 0,
                  lat: 6, guard: 1'b0};

        rst        = 1'b1;
        step_start = 1'b0;
        core_done  = 1'b0;
        mem_acc    = '0;
        aer_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ctrl0", {ce0, v0, busy0, sd0, a0, ts0, sc0, spk0}, '0);
        chk("reset_mem0", mem0, '0);
        chk("reset_all1", {ce1, v1, busy1, sd1, a1, ts1, sc1, spk1, mem1}, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_hold", {ce0, busy0}, 2'b00);

        for (int i = 0; i < 5; i++) run_step(vt[i]);

        // 3-bit counter reaches 8 steps here and must read zero again.
        for (int i = 0; i < 3; i++) run_step(vt[2]);
        chk("wrap3", {sc1, sc0}, {3'd0, 16'd8});

        mem_acc    = quad(40, 40, 40, 40);
        aer_ready  = 1'b0;
        step_start = 1'b1;
        @(negedge clk);
        step_start = 1'b0;
        @(negedge clk);
        core_done = 1'b1;
        for (int i = 0; i < 20 && !v0; i++) @(negedge clk);
        chk("rst_pre_valid", v0, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_mid_ctrl", {v0, ce0, busy0, sc0}, '0);
        chk("rst_mid_data", {spk0, mem0}, '0);
        chk("rst_mid_dut1", {v1, busy1, sc1}, '0);
        @(negedge clk);
        rst       = 1'b0;
        core_done = 1'b0;
        aer_ready = 1'b1;
        @(negedge clk);
        chk("rst_after_idle", {busy0, ce0, v0, sc0}, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spike_emitter.md
Name: spike_emitter

Overview:
- Output end of the neuromorphic core and the driver of each timestep.
- Sequences one timestep: enables the crossbar core and waits for its done. It then captures the accumulated membranes, thresholds them and applies the reset rule.
- Feeds spikes and updated membranes back to the core for the next timestep.
- Serialises fired neurons as address-event (AER) packets over a valid/ready handshake.

Parameters:
- MAX_NEURONS, 8, neuron count; must match the core.
- WIDTH, 32, signed membrane width.
- THRESH, 32, signed firing threshold.
- RESET_MODE, 0, 0 = reset-to-zero, 1 = subtract THRESH.
- TS_W, 16, timestep counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- step_start  in  1  request one timestep; sampled in IDLE only.
- core_enable  out  1  drives core enable; low clears core done.
- core_done  in  1  core timestep-complete flag.
- mem_acc  in  WIDTH x MAX_NEURONS  signed core mem_out.
- mem_next  out  WIDTH x MAX_NEURONS  signed; drives core mem_in.
- spk_vec  out  MAX_NEURONS  fired vector; drives core spk_in.
- aer_valid  out  1  event valid.
- aer_ready  in  1  sink ready.
- aer_addr  out  $clog2(MAX_NEURONS)  neuron index of event.
- aer_ts  out  TS_W  timestep of event.
- busy  out  1  high in any state except IDLE.
- step_done  out  1  one-cycle pulse at end of EMIT.
- step_count  out  TS_W  completed timesteps.

Behaviour:
- Reset values (asynchronous): all outputs 0, mem_next all 0, state IDLE, scan index 0.
- Reset mid-operation:
  - Immediate return to IDLE.
  - core_enable drops.
  - aer_valid drops without completing the handshake.
  - mem_next and spk_vec return to 0.
- FSM states: IDLE, RUN, FIRE, EMIT.
- IDLE:
  - step_start=1 -> RUN, core_enable<=1 on the same edge.
  - step_start=0 -> stay in IDLE.
- RUN:
  - Hold core_enable=1 until core_done=1 is sampled, then -> FIRE.
  - No timeout.
- FIRE (exactly one cycle):
  - Per neuron i: fire_i = (mem_acc[i] >= THRESH), signed compare.
  - spk_vec[i] <= fire_i.
  - Fired neuron: mem_next[i] <= 0 if RESET_MODE=0, else mem_acc[i]-THRESH, WIDTH-bit wrap.
  - Non-fired neuron: mem_next[i] <= mem_acc[i].
  - core_enable<=0, which clears core done. Go to EMIT with index 0.
- EMIT, scanning index k = 0..MAX_NEURONS-1:
  - spk_vec[k]=0: advance one cycle, aer_valid stays 0.
  - spk_vec[k]=1: aer_valid=1, aer_addr=k, aer_ts=step_count. All three stay stable until aer_ready=1 is sampled with aer_valid=1, then advance.
  - Valid may be high in the same cycle ready is already high: one event per cycle, no bubble.
  - After k=MAX_NEURONS-1 is resolved: step_done pulse, step_count += 1 (wraps at 2^TS_W), -> IDLE.
- Latency:
  - Step with zero spikes: RUN wait + 1 (FIRE) + MAX_NEURONS cycles.
  - With ready held high, each spike adds 0 extra cycles.
- step_start while busy is ignored (not queued).
- spk_vec and mem_next hold their values from FIRE until the next FIRE or reset.
- Events leave in ascending address order within a timestep.

Decomposition:
- Package snn_pkg:
  - emit_state_t enum (IDLE, RUN, FIRE, EMIT).
  - aer_event_t struct {addr, ts}.
  - Constant RESET_ZERO=0, RESET_SUB=1.
- Sub-module aer_tx:
  - Scans spk_vec, owns the valid/ready register slice and the scan index.
  - Start/finish handshake with the parent FSM.
- Threshold/reset logic stays inline in the FIRE state.

Test Plan:
- All tests use MAX_NEURONS=4 and THRESH=32.
- Reset then idle: outputs all 0; step_start pulse -> core_enable=1 the next cycle, busy=1.
- Mixed firing, RESET_MODE=0:
  - Stimulus: mem_acc={40,31,32,-5}, core_done=1, ready=1.
  - Required: spk_vec=4'b0101, mem_next={0,31,0,-5}.
  - Events addr 0 then addr 2, both ts=0; step_done pulses; step_count=1.
- RESET_MODE=1:
  - Stimulus: mem_acc={100,32,0,-40}.
  - Required: mem_next={68,0,0,-40}, spk_vec=4'b0011.
- Backpressure:
  - Stimulus: all 4 neurons fire, aer_ready low 5 cycles on event addr 1.
  - Required: addr/ts stable while valid is held; exactly 4 events in order 0,1,2,3; no duplicates.
- Reset asserted during EMIT with aer_valid=1 -> aer_valid=0 immediately, state IDLE, step_count=0.
- Guard and wrap behaviour:
  - step_start asserted while busy -> no extra step.
  - Run 65536 steps with TS_W=16 -> step_count wraps to 0.
  - Zero-spike step emits no aer_valid.
